// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART_TX between NUM_REQ byte sources with round-robin
//   arbitration. For each grant it latches the requester's byte and the parity
//   configuration, strobes DATA_VALID for one cycle, and follows TX_BUSY to
//   decide when the frame is over. The requester is then acknowledged. If
//   TX_BUSY never rises, the acknowledge comes with ERR after a timeout.
//
// Ports
//   CLK, RST      system clock (rising edge), async active-low reset
//   REQ           per-requester level request, held until its ACK
//   REQ_DATA      flattened bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   CFG_PAR_EN    parity enable, sampled at grant
//   CFG_PAR_TYP   parity type, sampled at grant
//   TX_BUSY       busy output of UART_TX
//   P_DATA        latched byte to UART_TX
//   DATA_VALID    one-cycle start strobe to UART_TX
//   PAR_EN        latched parity enable
//   PAR_TYP       latched parity type
//   ACK           one-hot, one-cycle completion pulse
//   ERR           one-cycle timeout flag, coincident with ACK
//   GRANT_ID      current or last granted requester
//   SCHED_BUSY    high whenever the FSM is not in IDLE
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a request while the transmitter is free
// ISSUE     | DATA_VALID strobe cycle; timeout counter cleared
// WAIT_BUSY | waiting for TX_BUSY to rise, timeout counter running
// WAIT_DONE | frame in progress; a falling TX_BUSY ends the frame
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic                          CFG_PAR_EN,
  input  logic                          CFG_PAR_TYP,
  input  logic                          TX_BUSY,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          DATA_VALID,
  output logic                          PAR_EN,
  output logic                          PAR_TYP,
  output logic [NUM_REQ-1:0]            ACK,
  output logic                          ERR,
  output logic [IDW-1:0]                GRANT_ID,
  output logic                          SCHED_BUSY
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [IDW:0]  NREQ_W   = (IDW+1)'(NUM_REQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  state_t                  state;
  logic [IDW-1:0]          last;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_next;
  logic                    pick_found;
  logic [IDW-1:0]          pick_idx;
  logic [IDW:0]            rr_sum;
  logic [IDW-1:0]          rr_idx;
  logic [DATA_WIDTH-1:0]   pick_data;
  logic [NUM_REQ-1:0]      ack_mask;

  assign cnt_next = cnt + 1'b1;

  // Round-robin search starting just after the last served requester.
  // last < NUM_REQ and k <= NUM_REQ, so a single subtraction handles wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_sum     = '0;
    rr_idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last} + (IDW+1)'(k);
      if (rr_sum >= NREQ_W) rr_sum = rr_sum - NREQ_W;
      rr_idx = rr_sum[IDW-1:0];
      if (!pick_found && REQ[rr_idx]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDW'(k)) pick_data = REQ_DATA[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    ack_mask = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      ack_mask[k] = (GRANT_ID == IDW'(k));
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      last       <= IDW'(NUM_REQ - 1);
      cnt        <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_EN     <= 1'b0;
      PAR_TYP    <= 1'b0;
      ACK        <= '0;
      ERR        <= 1'b0;
      GRANT_ID   <= '0;
      SCHED_BUSY <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      ACK        <= '0;
      ERR        <= 1'b0;
      case (state)
        IDLE: begin
          // The ACK cycle itself is spent in IDLE without arbitrating: the
          // acknowledged requester may still show its stale REQ here.
          if (ACK == '0 && pick_found && !TX_BUSY) begin
            state      <= ISSUE;
            GRANT_ID   <= pick_idx;
            P_DATA     <= pick_data;
            PAR_EN     <= CFG_PAR_EN;
            PAR_TYP    <= CFG_PAR_TYP;
            DATA_VALID <= 1'b1;
            SCHED_BUSY <= 1'b1;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (TX_BUSY) begin
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt_next;
            if (cnt_next == CNT_LAST) begin
              ACK        <= ack_mask;
              ERR        <= 1'b1;
              last       <= GRANT_ID;
              state      <= IDLE;
              SCHED_BUSY <= 1'b0;
            end
          end
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
            ACK        <= ack_mask;
            last       <= GRANT_ID;
            state      <= IDLE;
            SCHED_BUSY <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          SCHED_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   The main process drives requests, a small UART_TX busy model and the
//   requester agents, and pushes the expected grants and acknowledges. The
//   monitor process pops and compares them whenever DATA_VALID or ACK shows.
module tb_uart_tx_scheduler;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int BT    = 16;
  localparam int FRAME = 5;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [NR-1:0]  REQ = '0;
  logic [NR*DW-1:0] REQ_DATA = '0;
  logic           CFG_PAR_EN = 1'b0;
  logic           CFG_PAR_TYP = 1'b0;
  logic           TX_BUSY = 1'b0;
  logic [DW-1:0]  P_DATA;
  logic           DATA_VALID;
  logic           PAR_EN;
  logic           PAR_TYP;
  logic [NR-1:0]  ACK;
  logic           ERR;
  logic [1:0]     GRANT_ID;
  logic           SCHED_BUSY;

  uart_tx_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA),
    .CFG_PAR_EN(CFG_PAR_EN), .CFG_PAR_TYP(CFG_PAR_TYP), .TX_BUSY(TX_BUSY),
    .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .ACK(ACK), .ERR(ERR), .GRANT_ID(GRANT_ID), .SCHED_BUSY(SCHED_BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          pe;
    logic          pt;
    int            cyc;   // exact monitor cycle of the strobe, -1 = any
    int            gap;   // cycles since previous ACK, -1 = any
  } dv_t;

  typedef struct {
    logic [NR-1:0] ack;
    logic          err;
    int            lat;   // cycles from DATA_VALID to ACK
  } ack_t;

  dv_t  dv_q[$];
  ack_t ack_q[$];

  // main-process state
  int   zero_req = 0;
  int   tmo_req = 0;
  bit   final_req = 1'b0;
  bit   model_en = 1'b1;
  int   busy_left = 0;
  int   rearm[NR];
  int   m0;

  // monitor-process state
  int   tests = 0;
  int   fails = 0;
  int   mcyc = 0;
  int   zero_done = 0;
  int   tmo_seen = 0;
  bit   final_done = 1'b0;
  int   dv_cyc = 0;
  int   ack_cyc = -1000;
  logic [DW-1:0] hold_data;
  logic hold_pe;
  logic hold_pt;
  bit   unstable = 1'b0;
  dv_t  de;
  ack_t ae;

  logic [18:0] outs_all;
  assign outs_all = {P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ACK, ERR, GRANT_ID, SCHED_BUSY};

  function automatic void exp_dv(logic [1:0] id, logic [DW-1:0] d, logic pe, logic pt,
                                 int cyc, int gap);
    dv_t e;
    e.id = id; e.data = d; e.pe = pe; e.pt = pt; e.cyc = cyc; e.gap = gap;
    dv_q.push_back(e);
  endfunction

  function automatic void exp_ack(logic [NR-1:0] a, logic err, int lat);
    ack_t e;
    e.ack = a; e.err = err; e.lat = lat;
    ack_q.push_back(e);
  endfunction

  // One clock: UART_TX busy model, then requester agents reacting to ACK.
  task automatic step();
    @(posedge CLK); #1;
    if (model_en) begin
      if (DATA_VALID) begin
        TX_BUSY   = 1'b1;
        busy_left = FRAME;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) TX_BUSY = 1'b0;
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (ACK[i]) begin
        if (rearm[i] > 0) rearm[i]--;
        else REQ[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    RST       = 1'b0;
    REQ       = '0;
    TX_BUSY   = 1'b0;
    busy_left = 0;
    for (int i = 0; i < NR; i++) rearm[i] = 0;
    zero_req++;
    step();
    step();
    RST = 1'b1;
    step();
  endtask

  task automatic wait_dv();
    for (int k = 0; k < 50; k++) begin
      step();
      if (DATA_VALID) return;
    end
    tmo_req++;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      if (dv_q.size() == 0 && ack_q.size() == 0 && !SCHED_BUSY && ACK == '0 &&
          !TX_BUSY && busy_left == 0) return;
      step();
    end
    tmo_req++;
  endtask

  always @(negedge CLK) begin
    mcyc++;
    if (zero_done != zero_req) begin
      zero_done++;
      tests++;
      if (outs_all !== '0) begin
        fails++;
        $display("FAIL reset_state: outputs=%h required=0", outs_all);
      end
    end
    if (tmo_seen != tmo_req) begin
      tmo_seen++;
      tests++;
      fails++;
      $display("FAIL wait_timeout: DUT event did not arrive within the cycle budget");
    end
    if (DATA_VALID) begin
      tests++;
      if (dv_q.size() == 0) begin
        fails++;
        $display("FAIL dv_unexpected: grant=%0d data=%h required=no strobe", GRANT_ID, P_DATA);
      end else begin
        de = dv_q.pop_front();
        if ({GRANT_ID, P_DATA, PAR_EN, PAR_TYP} !== {de.id, de.data, de.pe, de.pt}) begin
          fails++;
          $display("FAIL dv_fields: got id=%0d data=%h pe=%b pt=%b required id=%0d data=%h pe=%b pt=%b",
                   GRANT_ID, P_DATA, PAR_EN, PAR_TYP, de.id, de.data, de.pe, de.pt);
        end
        if (de.cyc >= 0) begin
          tests++;
          if (mcyc != de.cyc) begin
            fails++;
            $display("FAIL dv_cycle: got %0d required %0d", mcyc, de.cyc);
          end
        end
        if (de.gap >= 0) begin
          tests++;
          if (mcyc - ack_cyc != de.gap) begin
            fails++;
            $display("FAIL ack_to_dv_gap: got %0d required %0d", mcyc - ack_cyc, de.gap);
          end
        end
      end
      dv_cyc    = mcyc;
      hold_data = P_DATA;
      hold_pe   = PAR_EN;
      hold_pt   = PAR_TYP;
      unstable  = 1'b0;
    end else if (SCHED_BUSY && {P_DATA, PAR_EN, PAR_TYP} !== {hold_data, hold_pe, hold_pt}) begin
      unstable = 1'b1;
    end
    if (ACK != '0 || ERR) begin
      tests++;
      if (ack_q.size() == 0) begin
        fails++;
        $display("FAIL ack_unexpected: ack=%b err=%b required none", ACK, ERR);
      end else begin
        ae = ack_q.pop_front();
        if ({ACK, ERR, SCHED_BUSY} !== {ae.ack, ae.err, 1'b0}) begin
          fails++;
          $display("FAIL ack_fields: got ack=%b err=%b busy=%b required ack=%b err=%b busy=0",
                   ACK, ERR, SCHED_BUSY, ae.ack, ae.err);
        end
        tests++;
        if (mcyc - dv_cyc != ae.lat) begin
          fails++;
          $display("FAIL ack_latency: got %0d required %0d", mcyc - dv_cyc, ae.lat);
        end
        tests++;
        if (unstable) begin
          fails++;
          $display("FAIL frame_stability: P_DATA/PAR_EN/PAR_TYP changed mid-frame, required stable");
        end
      end
      ack_cyc = mcyc;
    end
    if (final_req && !final_done) begin
      final_done = 1'b1;
      tests++;
      if (dv_q.size() != 0 || ack_q.size() != 0) begin
        fails++;
        $display("FAIL drained: pending dv=%0d ack=%0d required 0 0", dv_q.size(), ack_q.size());
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) rearm[i] = 0;
    do_reset();

    // single request with mid-frame input changes and REQ drop
    REQ_DATA[15:8] = 8'hA5; CFG_PAR_EN = 1'b1; CFG_PAR_TYP = 1'b0;
    exp_dv(2'd1, 8'hA5, 1'b1, 1'b0, -1, -1);
    exp_ack(4'b0010, 1'b0, 6);
    REQ = 4'b0010;
    wait_dv();
    REQ_DATA[15:8] = 8'h00; CFG_PAR_EN = 1'b0; CFG_PAR_TYP = 1'b1; REQ[1] = 1'b0;
    wait_idle();

    // contention: all four, served 0,1,2,3 at minimum spacing
    do_reset();
    REQ_DATA = {8'h43, 8'h32, 8'h21, 8'h10}; CFG_PAR_EN = 1'b0; CFG_PAR_TYP = 1'b1;
    exp_dv(2'd0, 8'h10, 1'b0, 1'b1, -1, -1); exp_ack(4'b0001, 1'b0, 6);
    exp_dv(2'd1, 8'h21, 1'b0, 1'b1, -1, 2);  exp_ack(4'b0010, 1'b0, 6);
    exp_dv(2'd2, 8'h32, 1'b0, 1'b1, -1, 2);  exp_ack(4'b0100, 1'b0, 6);
    exp_dv(2'd3, 8'h43, 1'b0, 1'b1, -1, 2);  exp_ack(4'b1000, 1'b0, 6);
    REQ = 4'b1111;
    wait_idle();

    // fairness: requester 0 keeps re-requesting, 2 waiting -> 0,2,0,2
    do_reset();
    REQ_DATA = {8'h00, 8'hC2, 8'h00, 8'hC0}; CFG_PAR_EN = 1'b1; CFG_PAR_TYP = 1'b1;
    rearm[0] = 1; rearm[2] = 1;
    exp_dv(2'd0, 8'hC0, 1'b1, 1'b1, -1, -1); exp_ack(4'b0001, 1'b0, 6);
    exp_dv(2'd2, 8'hC2, 1'b1, 1'b1, -1, 2);  exp_ack(4'b0100, 1'b0, 6);
    exp_dv(2'd0, 8'hC0, 1'b1, 1'b1, -1, 2);  exp_ack(4'b0001, 1'b0, 6);
    exp_dv(2'd2, 8'hC2, 1'b1, 1'b1, -1, 2);  exp_ack(4'b0100, 1'b0, 6);
    REQ = 4'b0101;
    wait_idle();

    // timeout: TX_BUSY never rises
    do_reset();
    model_en = 1'b0;
    REQ_DATA[23:16] = 8'h5C; CFG_PAR_EN = 1'b1; CFG_PAR_TYP = 1'b1;
    exp_dv(2'd2, 8'h5C, 1'b1, 1'b1, -1, -1);
    exp_ack(4'b0100, 1'b1, BT);
    REQ = 4'b0100;
    wait_idle();
    model_en = 1'b1;

    // blocking: TX_BUSY high in IDLE holds off the grant
    do_reset();
    REQ_DATA[7:0] = 8'h81; CFG_PAR_EN = 1'b0; CFG_PAR_TYP = 1'b0;
    m0 = mcyc;
    exp_dv(2'd0, 8'h81, 1'b0, 1'b0, m0 + 7, -1);
    exp_ack(4'b0001, 1'b0, 6);
    REQ = 4'b0001;
    TX_BUSY = 1'b1;
    repeat (5) step();
    TX_BUSY = 1'b0;
    wait_idle();

    // reset during WAIT_DONE: no ACK for the aborted frame
    do_reset();
    REQ_DATA[15:8] = 8'h77; CFG_PAR_EN = 1'b1; CFG_PAR_TYP = 1'b0;
    exp_dv(2'd1, 8'h77, 1'b1, 1'b0, -1, -1);
    REQ = 4'b0010;
    wait_dv();
    repeat (3) step();
    do_reset();
    REQ_DATA[31:24] = 8'h3C;
    exp_dv(2'd3, 8'h3C, 1'b1, 1'b0, -1, -1);
    exp_ack(4'b1000, 1'b0, 6);
    REQ = 4'b1000;
    wait_idle();
    repeat (4) step();

    final_req = 1'b1;
    for (int k = 0; k < 5 && !final_done; k++) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART_TX transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Grants one requester, holds its byte and the parity configuration stable, pulses DATA_VALID, then tracks the transmitter's Busy output until the frame completes.
- Acknowledges the requester at frame end, or on a timeout if Busy never rises.
- Sits between the application-side byte sources and UART_TX.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width; must match UART_TX P_DATA.
- BUSY_TIMEOUT, 16, maximum cycles waited for TX_BUSY to rise after DATA_VALID (>=2).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- REQ  input  NUM_REQ  per-requester level request; held until that requester's ACK.
- REQ_DATA  input  NUM_REQ*DATA_WIDTH  flattened bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- CFG_PAR_EN  input  1  parity enable, sampled at grant.
- CFG_PAR_TYP  input  1  parity type, sampled at grant.
- TX_BUSY  input  1  Busy output of UART_TX.
- P_DATA  output  DATA_WIDTH  byte to UART_TX.
- DATA_VALID  output  1  one-cycle start strobe to UART_TX.
- PAR_EN  output  1  latched parity enable to UART_TX.
- PAR_TYP  output  1  latched parity type to UART_TX.
- ACK  output  NUM_REQ  one-hot, one-cycle completion pulse.
- ERR  output  1  one-cycle timeout pulse, coincident with ACK.
- GRANT_ID  output  clog2(NUM_REQ)  index of the current or last granted requester.
- SCHED_BUSY  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (RST low, asynchronous): state IDLE; all outputs 0; timeout counter 0; round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE, when any REQ is high and TX_BUSY=0:
  - Grant the first requester with REQ high, searching from last+1 upward with wrap.
  - Latch that requester's REQ_DATA into P_DATA, CFG_PAR_EN into PAR_EN, CFG_PAR_TYP into PAR_TYP.
  - Set GRANT_ID and go to ISSUE.
- IDLE, when TX_BUSY=1: no grant (an external or stale frame is still in progress).
- ISSUE: DATA_VALID=1 for exactly this one cycle; counter cleared; go to WAIT_BUSY.
- WAIT_BUSY:
  - TX_BUSY=1: go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 with TX_BUSY still 0: pulse ACK[GRANT_ID] and ERR together for one cycle, update last=GRANT_ID, go to IDLE.
- WAIT_DONE: on TX_BUSY=0, pulse ACK[GRANT_ID] for one cycle (ERR=0), update last=GRANT_ID, go to IDLE.
- Stability: P_DATA, PAR_EN and PAR_TYP change only at a grant. They are held through the whole frame and retain their value in IDLE.
- Spacing: the minimum gap from an ACK to the next DATA_VALID is 2 cycles (ACK cycle, IDLE, then ISSUE).
- Requester contract: a requester drops REQ on the edge after it sees ACK. The scheduler evaluates REQ only in IDLE, so a stale REQ sampled in the ACK cycle is never double-granted.
- REQ dropped mid-frame: ignored; the frame completes and ACK still pulses.
- REQ_DATA or CFG inputs changing mid-frame: ignored.
- Simultaneous requests: strict round-robin. A requester holding REQ continuously is served within NUM_REQ grants.
- Single requester: may be granted back-to-back.
- Reset mid-frame: DATA_VALID and ACK are forced to 0 immediately, no ACK is issued for the aborted frame, and the pointer returns to NUM_REQ-1.
- TX_BUSY glitch low in WAIT_DONE: treated as frame end (no filtering).

Test Plan:
- Single request: REQ=4'b0010 with byte 0xA5, CFG_PAR_EN=1, CFG_PAR_TYP=0, UART_TX model → GRANT_ID=1, one DATA_VALID cycle with P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 stable until TX_BUSY falls, then a single ACK=4'b0010 and ERR=0.
- Contention: REQ=4'b1111 held, each requester dropping REQ after its ACK → grants in order 0,1,2,3 and exactly one ACK per requester.
- Fairness: requester 0 re-raises REQ immediately after each ACK while requester 2 is waiting → order 0,2,0,2, never 0,0.
- Timeout: TX_BUSY tied 0, REQ=4'b0100 → exactly 16 cycles after DATA_VALID, ACK=4'b0100 and ERR=1 together for one cycle, then back in IDLE.
- Blocking: TX_BUSY=1 while in IDLE with REQ=4'b0001 → no DATA_VALID until TX_BUSY falls; grant on the next cycle.
- Reset mid-frame: RST low during WAIT_DONE → all outputs 0 immediately, no ACK. After release with REQ=4'b1000, requester 3 is granted and ACK'd normally.
